// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control path: state codes, opcodes,
// ALUOp codes (also used by ALUControl) and the decoded control word.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_REXEC   = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_IEXEC   = 4'd10,
        S_IWB     = 4'd11
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LW    = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_JMP   = 4'b0101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_OFFSET = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // fetch_wr marks the FETCH-cycle IR/PC writes that only fire once memory is ready
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       fetch_wr;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_word_t;

    function automatic logic opcode_legal(input logic [3:0] op);
        return (op <= OP_JMP);
    endfunction

endpackage

// File: rtl/ctrl_word_decode.sv
// Pure combinational map from FSM state to the Moore control word.
module ctrl_word_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t     state,
    output ctrl_word_t cw
);

    always_comb begin
        cw = '0;
        case (state)
            S_FETCH: begin
                cw.mem_read  = 1'b1;
                cw.fetch_wr  = 1'b1;
                cw.alu_src_b = SRCB_FOUR;
                cw.alu_op    = ALUOP_ADD;
            end
            S_DECODE: begin
                cw.alu_src_b = SRCB_OFFSET;
                cw.alu_op    = ALUOP_ADD;
            end
            S_MEMADDR: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                cw.mem_read = 1'b1;
                cw.iord     = 1'b1;
            end
            S_MEMWB: begin
                cw.reg_write  = 1'b1;
                cw.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                cw.mem_write = 1'b1;
                cw.iord      = 1'b1;
            end
            S_REXEC: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_REG;
                cw.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                cw.reg_write = 1'b1;
                cw.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                cw.alu_src_a     = 1'b1;
                cw.alu_op        = ALUOP_SUB;
                cw.pc_write_cond = 1'b1;
                cw.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                cw.pc_write  = 1'b1;
                cw.pc_source = PCSRC_JUMP;
            end
            S_IEXEC: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALUOP_IMM;
            end
            S_IWB: begin
                cw.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU main control FSM: state register, next-state logic and
// reset/MemReady gating of the write enables around the decoded control word.
module multicycle_control
    import cpu_ctrl_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] State,
    output logic       Illegal
);

    state_t     cur_state;
    state_t     next_state;
    state_t     view_state;
    ctrl_word_t cw;
    logic       run;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = S_FETCH;
        case (cur_state)
            S_FETCH:   next_state = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:     next_state = S_REXEC;
                    OP_ADDI:      next_state = S_IEXEC;
                    OP_LW, OP_SW: next_state = S_MEMADDR;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_JMP:       next_state = S_JUMP;
                    default:      next_state = S_FETCH;
                endcase
            end
            // Opcode is re-sampled here; anything but LW/SW abandons the access
            S_MEMADDR: begin
                if (Opcode == OP_LW) begin
                    next_state = S_MEMRD;
                end else if (Opcode == OP_SW) begin
                    next_state = S_MEMWR;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_MEMRD:   next_state = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:   next_state = MemReady ? S_FETCH : S_MEMWR;
            S_REXEC:   next_state = S_RWB;
            S_IEXEC:   next_state = S_IWB;
            default:   next_state = S_FETCH;
        endcase
    end

    // During reset the datapath selects show FETCH values while every enable is held low
    assign run        = ~Reset;
    assign view_state = Reset ? S_FETCH : cur_state;

    ctrl_word_decode u_decode (
        .state (view_state),
        .cw    (cw)
    );

    assign PCWrite     = run & (cw.pc_write | (cw.fetch_wr & MemReady));
    assign IRWrite     = run & cw.fetch_wr & MemReady;
    assign PCWriteCond = run & cw.pc_write_cond;
    assign MemRead     = run & cw.mem_read;
    assign MemWrite    = run & cw.mem_write;
    assign RegWrite    = run & cw.reg_write;
    assign Illegal     = run & (cur_state == S_DECODE) & ~opcode_legal(Opcode);

    assign IorD     = cw.iord;
    assign MemtoReg = cw.mem_to_reg;
    assign RegDst   = cw.reg_dst;
    assign ALUSrcA  = cw.alu_src_a;
    assign ALUSrcB  = cw.alu_src_b;
    assign ALUOp    = cw.alu_op;
    assign PCSource = cw.pc_source;
    assign State    = view_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference model plus directed
// sequences with literal expectations, followed by a randomized run.
module tb_multicycle_control;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [3:0] Opcode;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Illegal;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 Clock = ~Clock;

    multicycle_control dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Opcode      (Opcode),
        .MemReady    (MemReady),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .State       (State),
        .Illegal     (Illegal)
    );

    // Reference model: an instruction is FETCH, DECODE, then a per-opcode list of
    // steps; FETCH, memory read and memory write steps repeat while memory is busy.
    int         m_st    = 0;
    bit         m_valid = 1'b0;
    int         plan[$];
    logic [3:0] dec_op  = 4'd0;

    always @(posedge Clock) begin
        if (Reset) begin
            m_st    = 0;
            m_valid = 1'b1;
            plan.delete();
        end else if (m_valid) begin
            if ((m_st == 0 || m_st == 3 || m_st == 5) && !MemReady) begin
                m_st = m_st;
            end else if (m_st == 0) begin
                m_st = 1;
            end else begin
                if (m_st == 1) begin
                    dec_op = Opcode;
                    case (Opcode)
                        4'd0:    plan = '{6, 7};
                        4'd1:    plan = '{10, 11};
                        4'd2:    plan = '{2, 3, 4};
                        4'd3:    plan = '{2, 5};
                        4'd4:    plan = '{8};
                        4'd5:    plan = '{9};
                        default: plan.delete();
                    endcase
                end
                m_st = (plan.size() > 0) ? plan.pop_front() : 0;
            end
        end
    end

    // Expected outputs straight from the per-state output rules
    function automatic logic [20:0] spec_out(input int st, input logic mr,
                                             input logic rst, input logic [3:0] op);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, ill;
        logic [1:0] sb, aop, pcs;
        logic [3:0] s;
        s = rst ? 4'd0 : 4'(st);
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, ill} = '0;
        sb = 2'd0; aop = 2'd0; pcs = 2'd0;
        case (s)
            4'd0:  begin mrd = 1; sb = 2'd1; irw = mr; pcw = mr; end
            4'd1:  begin sb = 2'd3; ill = (op > 4'd5); end
            4'd2:  begin sa = 1; sb = 2'd2; end
            4'd3:  begin mrd = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mwr = 1; iord = 1; end
            4'd6:  begin sa = 1; aop = 2'd2; end
            4'd7:  begin rw = 1; rdst = 1; end
            4'd8:  begin sa = 1; aop = 2'd1; pcwc = 1; pcs = 2'd1; end
            4'd9:  begin pcw = 1; pcs = 2'd2; end
            4'd10: begin sa = 1; sb = 2'd2; aop = 2'd3; end
            4'd11: begin rw = 1; end
            default: ;
        endcase
        if (rst) {pcw, pcwc, mrd, mwr, irw, rw, ill} = '0;
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, aop, pcs, s, ill};
    endfunction

    logic [20:0] got_vec, exp_vec;
    assign got_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                      RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, State, Illegal};

    always @(negedge Clock) begin
        #4;
        if (m_valid || Reset) begin
            exp_vec = spec_out(m_st, MemReady, Reset, Opcode);
            n_chk++;
            if (got_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t got=%h exp=%h (model state %0d)",
                         $time, got_vec, exp_vec, m_st);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic mr, input logic [3:0] op);
        @(negedge Clock);
        Reset    = rst;
        MemReady = mr;
        Opcode   = op;
        #4;
    endtask

    // Entered while FETCH is displayed; counts cycles until the next FETCH.
    task automatic latency(input string name, input logic [3:0] op, input int exp);
        int n = 1;
        bit back = 1'b0;
        while (n < 20 && !back) begin
            cyc(1'b0, 1'b1, op);
            if (State == 4'd0) back = 1'b1;
            else n++;
        end
        if (!back) chk({name, "_timeout"}, 0, 1);
        else chk(name, n, exp);
    endtask

    task automatic cyc_rand();
        logic [3:0] op;
        @(negedge Clock);
        Reset    = ($urandom_range(0, 49) == 0);
        MemReady = ($urandom_range(0, 3) != 0);
        if (m_valid && m_st == 2) op = dec_op;
        else if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(0, 15));
        else op = 4'($urandom_range(0, 5));
        Opcode = op;
        #4;
    endtask

    int seq_r[4]  = '{1, 6, 7, 0};
    int seq_lw[7] = '{1, 2, 3, 3, 3, 4, 0};
    bit mr_lw[7]  = '{1, 1, 0, 0, 1, 1, 1};

    initial begin
        Reset = 1'b1; MemReady = 1'b1; Opcode = 4'd0;

        repeat (3) begin
            cyc(1'b1, 1'b1, 4'($urandom_range(0, 15)));
            chk("rst_enables", int'({PCWrite, PCWriteCond, MemRead, MemWrite,
                                     IRWrite, RegWrite, Illegal}), 0);
            chk("rst_state", State, 0);
            chk("rst_alusrcb", ALUSrcB, 1);
        end

        cyc(1'b0, 1'b1, 4'd0);
        chk("first_fetch_state", State, 0);
        chk("first_fetch_irwrite", IRWrite, 1);

        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 4'b0000);
            chk("rtype_state", State, seq_r[i]);
            chk("rtype_regwrite", RegWrite, (seq_r[i] == 7) ? 1 : 0);
            if (seq_r[i] == 7) chk("rtype_regdst", RegDst, 1);
            if (seq_r[i] == 6) chk("rtype_aluop", ALUOp, 2);
        end

        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, mr_lw[i], 4'b0010);
            chk("lw_state", State, seq_lw[i]);
            if (seq_lw[i] == 3) chk("lw_memrd_iord", int'({MemRead, IorD}), 3);
            if (seq_lw[i] == 4) chk("lw_memtoreg", MemtoReg, 1);
        end

        latency("lat_sw", 4'b0011, 4);
        latency("lat_beq", 4'b0100, 3);
        latency("lat_jmp", 4'b0101, 3);
        latency("lat_rtype", 4'b0000, 4);
        latency("lat_addi", 4'b0001, 4);
        latency("lat_lw", 4'b0010, 5);

        cyc(1'b0, 1'b1, 4'b1111);
        chk("illegal_decode", int'({State, Illegal}), 3);
        chk("illegal_no_writes", int'({RegWrite, MemWrite, PCWriteCond}), 0);
        cyc(1'b0, 1'b1, 4'b1111);
        chk("illegal_next", int'({State, Illegal}), 0);

        cyc(1'b0, 1'b1, 4'b0011);
        cyc(1'b0, 1'b1, 4'b0011);
        cyc(1'b0, 1'b0, 4'b0011);
        chk("sw_memwr", int'({State, MemWrite}), 11);
        cyc(1'b0, 1'b0, 4'b0011);
        chk("sw_memwr_hold", int'({State, MemWrite}), 11);
        cyc(1'b1, 1'b0, 4'b0011);
        chk("rst_in_memwr", int'({State, MemWrite}), 0);
        cyc(1'b0, 1'b0, 4'b0011);
        chk("after_rst_state", State, 0);
        chk("after_rst_nowrite", int'({PCWrite, IRWrite, MemWrite, RegWrite}), 0);

        cyc(1'b0, 1'b1, 4'b0100);
        chk("fetch_stall_release", int'({State, IRWrite, PCWrite}), 3);
        latency("lat_beq_stalled_entry", 4'b0100, 3);

        for (int i = 0; i < 3000; i++) cyc_rand();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset.
REQ-002 SHALL have these ports, clock and reset first:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high
- Opcode  in  4  instruction bits [15:12] from the instruction register (IR)
- MemReady  in  1  memory access completes this cycle
- PCWrite  out  1  unconditional PC write
- PCWriteCond  out  1  PC write when ALU Zero is set
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1
- MemWrite  out  1
- IRWrite  out  1
- MemtoReg  out  1
- RegDst  out  1
- RegWrite  out  1
- ALUSrcA  out  1
- ALUSrcB  out  2
- ALUOp  out  2  to ALUControl: 00 add, 01 sub, 10 Funct, 11 immediate
- PCSource  out  2
- State  out  4  current state, for debug
- Illegal  out  1  undefined opcode seen in DECODE

Function
REQ-003 SHALL be a Moore FSM; every output except Illegal and the MemReady-gated enables SHALL depend on State only.
REQ-004 State encodings SHALL be: FETCH=0, DECODE=1, MEMADDR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11. Codes 12-15 SHALL go to FETCH on the next edge.
REQ-005 Opcodes SHALL be: 0000 R-type, 0001 ADDI, 0010 LW, 0011 SW, 0100 BEQ, 0101 JMP. All others are illegal.
REQ-006 Outputs not listed in REQ-007 to REQ-017 SHALL be 0 in that state.
REQ-007 FETCH: MemRead=1, ALUSrcB=01, ALUOp=00. IRWrite=PCWrite=MemReady. Stay in FETCH while MemReady=0, else go to DECODE.
REQ-008 DECODE: ALUSrcB=11, ALUOp=00. Next state: R-type to REXEC, ADDI to IEXEC, LW or SW to MEMADDR, BEQ to BRANCH, JMP to JUMP, illegal to FETCH with Illegal=1 for this cycle only.
REQ-009 MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD for LW, MEMWR for SW.
REQ-010 MEMRD: MemRead=1, IorD=1. Hold until MemReady=1, then go to MEMWB.
REQ-011 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Go to FETCH.
REQ-012 MEMWR: MemWrite=1, IorD=1. Hold until MemReady=1, then go to FETCH.
REQ-013 REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to RWB.
REQ-014 RWB: RegWrite=1, RegDst=1. Go to FETCH.
REQ-015 BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01. Go to FETCH.
REQ-016 JUMP: PCWrite=1, PCSource=10. Go to FETCH.
REQ-017 IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11. Go to IWB. IWB: RegWrite=1, RegDst=0. Go to FETCH.
REQ-018 With MemReady tied to 1, FETCH-to-FETCH latency SHALL be: BEQ and JMP 3 cycles; R-type, ADDI and SW 4 cycles; LW 5 cycles. Each MemReady=0 cycle in FETCH, MEMRD or MEMWR SHALL add exactly one cycle.
REQ-019 Opcode SHALL be sampled only in DECODE and MEMADDR. Changes in any other state SHALL have no effect.

Reset
REQ-020 Reset=1 at a rising edge SHALL set State=FETCH, overriding any transition, including mid-instruction and during MemReady waits.
REQ-021 While Reset=1, SHALL force PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite and Illegal to 0 combinationally. Every other output SHALL show the FETCH value.
REQ-022 On the first edge after Reset falls, the FSM SHALL start a fetch, with no spurious write.

Structure
REQ-023 The shared package cpu_ctrl_pkg SHALL hold the state encodings, opcode constants and ALUOp constants. ALUControl SHALL reuse the ALUOp constants.
REQ-024 SHALL contain one sub-module, ctrl_word_decode: combinational, State to control word. The next-state logic and state register SHALL stay in multicycle_control.

Verification
REQ-025 Reset, then Opcode=0000 with MemReady=1 -> State sequence 0,1,6,7,0. RegWrite=1 only in state 7, with RegDst=1. ALUOp=10 in state 6.
REQ-026 Opcode=0010, MemReady=0 for 2 cycles in MEMRD -> sequence 0,1,2,3,3,3,4,0. MemRead and IorD=1 held throughout MEMRD. MemtoReg=1 in state 4.
REQ-027 Opcode=0011, then Opcode=0100, then Opcode=0101 -> 4, 3 and 3 cycles respectively. MemWrite=1 only in MEMWR. PCWriteCond=1 with ALUOp=01 in BRANCH. PCSource=10 in JUMP.
REQ-028 Opcode=1111 -> Illegal=1 for exactly one cycle in DECODE, next State=0, and no RegWrite, MemWrite or PCWriteCond.
REQ-029 Reset asserted in MEMWR while MemReady=0 -> MemWrite=0 in the same cycle, State=0 after the edge. Reset held 3 cycles -> no enable goes high.
